// File: rtl/fpga9685_pkg.sv
// Shared definitions for the PCA9685-style register sequencer: FSM encoding,
// register-map size and well-known register addresses.
package fpga9685_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGetPtr = 2'd1,
    StWrData = 2'd2,
    StRdData = 2'd3
  } state_e;

  localparam int unsigned NUM_REGS = 70;

  localparam logic [7:0] MODE1        = 8'h00;
  localparam logic [7:0] LED0_ON_L    = 8'h06;
  localparam logic [7:0] ALL_LED_ON_L = 8'hFA;
  localparam logic [7:0] PRESCALE     = 8'hFE;

  localparam int unsigned MODE1_AI_BIT = 5;

endpackage

// File: rtl/regfile_arb.sv
// Two-requester fixed-priority port mux for the single-port register file.
// The I2C sequencer always wins; the PWM scanner is granted only in idle cycles.
module regfile_arb #(
  parameter int unsigned AW = 8
) (
  input  logic          i2c_we_i,
  input  logic          i2c_re_i,
  input  logic [AW-1:0] i2c_addr_i,
  input  logic          pwm_req_i,
  input  logic [AW-1:0] pwm_addr_i,
  output logic [AW-1:0] addr_o,
  output logic          we_o,
  output logic          re_o,
  output logic          gnt_o
);

  logic i2c_op;

  // Port ownership: I2C op if present this cycle, otherwise a pending PWM read.
  always_comb begin
    i2c_op = i2c_we_i | i2c_re_i;
    gnt_o  = pwm_req_i & ~i2c_op;
    addr_o = i2c_op ? i2c_addr_i : pwm_addr_i;
    we_o   = i2c_we_i;
    re_o   = i2c_re_i | gnt_o;
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// Turns the I2C target's byte stream into register-file accesses: first written
// byte sets the pointer, later bytes write, read requests fetch at the pointer.
// Register-file strobes are registered (event cycle + 1); read data is returned
// on tx_data_o with tx_valid_o two cycles after the request.
module i2c_reg_sequencer #(
  parameter int unsigned NUM_REGS = fpga9685_pkg::NUM_REGS,
  parameter int unsigned AW       = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          rw_i,
  input  logic          stop_i,
  input  logic          rx_valid_i,
  input  logic [7:0]    rx_data_i,
  input  logic          tx_req_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          ai_i,
  output logic          busy_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [7:0]    reg_wdata_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  input  logic [7:0]    reg_rdata_i,
  input  logic          pwm_req_i,
  input  logic [AW-1:0] pwm_addr_i,
  output logic          pwm_gnt_o,
  output logic [7:0]    pwm_rdata_o
);

  import fpga9685_pkg::*;

  localparam logic [AW-1:0] LastReg = AW'(NUM_REGS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ptr_load, wr_evt, rd_evt, in_range;

  // Registered I2C op stage and read-return pipeline.
  logic          i2c_we_q, i2c_re_q, rd_pend_q, tx_valid_q, tx_oor_q;
  logic [AW-1:0] i2c_addr_q;
  logic [7:0]    wdata_q, tx_hold_q, tx_byte;

  assign in_range = 32'(ptr_q) < NUM_REGS;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // FSM next state: start beats stop, both beat byte events.
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = rw_i ? StRdData : StGetPtr;
    end else if (stop_i) begin
      state_d = StIdle;
    end else if (state_q == StGetPtr && rx_valid_i) begin
      state_d = StWrData;
    end
  end

  // FSM outputs: decode which byte event is honoured this cycle.
  always_comb begin
    ptr_load = 1'b0;
    wr_evt   = 1'b0;
    rd_evt   = 1'b0;
    if (!start_i && !stop_i) begin
      unique case (state_q)
        StGetPtr: ptr_load = rx_valid_i;
        StWrData: wr_evt   = rx_valid_i;
        StRdData: rd_evt   = tx_req_i;
        default:  ;
      endcase
    end
  end

  // Pointer next value: load, or auto-increment with wrap at the last register.
  always_comb begin
    ptr_d = ptr_q;
    if (ptr_load) begin
      ptr_d = AW'(rx_data_i);
    end else if ((wr_evt || rd_evt) && ai_i) begin
      ptr_d = (ptr_q == LastReg) ? '0 : ptr_q + AW'(1);
    end
  end

  // Pointer register; survives STOP so write-pointer/STOP/read works.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  // Register-file op stage plus the two-cycle read-return pipeline.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i2c_we_q   <= 1'b0;
      i2c_re_q   <= 1'b0;
      i2c_addr_q <= '0;
      wdata_q    <= '0;
      rd_pend_q  <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_oor_q   <= 1'b0;
      tx_hold_q  <= '0;
    end else begin
      i2c_we_q   <= wr_evt & in_range;
      i2c_re_q   <= rd_evt & in_range;
      if (wr_evt || rd_evt) i2c_addr_q <= ptr_q;
      if (wr_evt)           wdata_q    <= rx_data_i;
      rd_pend_q  <= rd_evt;
      tx_valid_q <= rd_pend_q;
      // An out-of-range read had no strobe, so reg_rdata_i is meaningless.
      tx_oor_q   <= rd_pend_q & ~i2c_re_q;
      if (tx_valid_q) tx_hold_q <= tx_byte;
    end
  end

  // Read data is live on reg_rdata_i in the tx_valid cycle, then held.
  always_comb begin
    tx_byte   = tx_oor_q ? 8'h00 : reg_rdata_i;
    tx_data_o = tx_valid_q ? tx_byte : tx_hold_q;
  end

  assign tx_valid_o  = tx_valid_q;
  assign busy_o      = (state_q != StIdle);
  assign reg_wdata_o = wdata_q;
  assign pwm_rdata_o = reg_rdata_i;

  regfile_arb #(
    .AW (AW)
  ) u_arb (
    .i2c_we_i   (i2c_we_q),
    .i2c_re_i   (i2c_re_q),
    .i2c_addr_i (i2c_addr_q),
    .pwm_req_i  (pwm_req_i),
    .pwm_addr_i (pwm_addr_i),
    .addr_o     (reg_addr_o),
    .we_o       (reg_we_o),
    .re_o       (reg_re_o),
    .gnt_o      (pwm_gnt_o)
  );

endmodule
